// File: rtl/hgcal_input_quant_pack.sv
// Input stage of the HGCAL autoencoder: 2-bit threshold quantiser feeding a frame packer for layer 0.
// Optional LNQ_FRAME_CHECK_EN: checks s_last against the sample count and pulses frame_err on mismatch.
module hgcal_input_quant_pack #(
    parameter int IN_W   = 8,
    parameter int Q_W    = 2,
    parameter int N_FEAT = 48,
    parameter int THR0   = 32,
    parameter int THR1   = 96,
    parameter int THR2   = 192
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IN_W-1:0]         s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N_FEAT*Q_W-1:0]   m_data,
    output logic                    frame_err
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and ready never looks at valid.

    localparam int CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_FEAT - 1);
    localparam logic [IN_W-1:0]  T0 = IN_W'(THR0);
    localparam logic [IN_W-1:0]  T1 = IN_W'(THR1);
    localparam logic [IN_W-1:0]  T2 = IN_W'(THR2);

    logic [CNT_W-1:0]            cnt;
    // The final slot is never stored: it comes straight from the live code on completion.
    logic [(N_FEAT-1)*Q_W-1:0]   acc;
    logic [Q_W-1:0]              code;
    logic                        last_slot;
    logic                        accept;
    logic                        complete;
    logic                        wrap;

    always_comb begin
        code = Q_W'(0);
        if (s_data >= T2)
            code = Q_W'(3);
        else if (s_data >= T1)
            code = Q_W'(2);
        else if (s_data >= T0)
            code = Q_W'(1);
    end

    assign last_slot = (cnt == LAST_CNT);
    // Only the closing sample has to wait for a held frame to drain.
    assign s_ready   = !(last_slot && m_valid && !m_ready);
    assign accept    = s_valid && s_ready;

`ifdef LNQ_FRAME_CHECK_EN
    logic early_last;
    logic missing_last;
    logic frame_err_q;

    assign early_last   = accept && s_last && !last_slot;
    assign missing_last = accept && last_slot && !s_last;
    assign complete     = accept && last_slot && s_last;
    assign wrap         = complete || early_last || missing_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_err_q <= 1'b0;
        else
            frame_err_q <= early_last || missing_last;
    end

    assign frame_err = frame_err_q;
`else
    logic unused_last;

    assign complete    = accept && last_slot;
    assign wrap        = complete;
    assign unused_last = s_last;
    assign frame_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            if (wrap)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            for (int k = 0; k < N_FEAT - 1; k++) begin
                if (cnt == CNT_W'(k))
                    acc[k*Q_W +: Q_W] <= code;
            end
        end
    end

    // A completion on the same edge as a drain keeps m_valid high with fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (complete) begin
            m_valid <= 1'b1;
            m_data  <= {code, acc};
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hgcal_input_quant_pack.sv
// Directed bench for hgcal_input_quant_pack: packing, thresholds, backpressure, streaming, reset and framing.
module tb_hgcal_input_quant_pack;

    localparam int NF = 48;
    localparam int DW = NF * 2;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          frame_err;

    int vectors;
    int miscompares;
    logic [DW-1:0] exp_q[$];
    logic [7:0]    cur[NF];

    hgcal_input_quant_pack dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .frame_err(frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish before it");
        $fatal(1, "timeout");
    end

    function automatic logic [1:0] ref_code(input logic [7:0] d);
        if (d >= 8'd192) return 2'd3;
        if (d >= 8'd96)  return 2'd2;
        if (d >= 8'd32)  return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [7:0] val(input int f, input int k);
        return 8'((k * 53 + f * 29 + 7) % 256);
    endfunction

    function automatic logic [DW-1:0] build();
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < NF; k++) r[k*2 +: 2] = ref_code(cur[k]);
        return r;
    endfunction

    task automatic fill(input int f);
        for (int k = 0; k < NF; k++) cur[k] = val(f, k);
    endtask

    // Presents one sample for one cycle; called and returns at a falling edge.
    task automatic drive(input logic [7:0] d, input logic last, output logic acc);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        acc     = s_ready;
        @(negedge clk);
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] z8;
        z8 = 8'd0;
        rst_n = 1'b1; s_valid = 1'b0; s_data = z8; s_last = 1'b0; m_ready = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid_in: got %b want 0", m_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        vectors++;
        if (m_data !== '0) begin miscompares++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        vectors++;
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        vectors++;
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_full_frame();
        logic a;
        m_ready = 1'b1;
        fill(0);
        exp_q.push_back(build());
        for (int k = 0; k < NF; k++) begin
            drive(cur[k], k == NF - 1, a);
            vectors++;
            if (a !== 1'b1) begin miscompares++; $display("FAIL full_accept[%0d]: got %b want 1", k, a); end
            vectors++;
            if (m_valid !== (k == NF - 1)) begin miscompares++; $display("FAIL full_m_valid[%0d]: got %b want %b", k, m_valid, k == NF - 1); end
        end
        idle();
        vectors++;
        if (m_data !== exp_q[0]) begin miscompares++; $display("FAIL full_m_data: got %h want %h", m_data, exp_q[0]); end
        void'(exp_q.pop_front());
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b0) begin miscompares++; $display("FAIL full_m_valid_drop: got %b want 0", m_valid); end
    endtask

    task automatic test_thresholds();
        logic a;
        logic [7:0] tv[8];
        logic [1:0] tc[8];
        tv = '{8'd31, 8'd32, 8'd95, 8'd96, 8'd191, 8'd192, 8'd255, 8'd0};
        tc = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        m_ready = 1'b1;
        for (int k = 0; k < NF; k++) cur[k] = (k < 8) ? tv[k] : 8'd0;
        for (int k = 0; k < NF; k++) drive(cur[k], k == NF - 1, a);
        idle();
        vectors++;
        if (m_valid !== 1'b1) begin miscompares++; $display("FAIL thr_m_valid: got %b want 1", m_valid); end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (m_data[k*2 +: 2] !== tc[k]) begin miscompares++; $display("FAIL thr_slot[%0d]: got %0d want %0d", k, m_data[k*2 +: 2], tc[k]); end
        end
        vectors++;
        if (m_data[DW-1:16] !== '0) begin miscompares++; $display("FAIL thr_upper: got %h want 0", m_data[DW-1:16]); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic a;
        logic [DW-1:0] fa, fb;
        m_ready = 1'b0;
        fill(1);
        fa = build();
        for (int k = 0; k < NF; k++) drive(cur[k], k == NF - 1, a);
        vectors++;
        if (m_valid !== 1'b1 || m_data !== fa) begin miscompares++; $display("FAIL bp_first: got %b/%h want 1/%h", m_valid, m_data, fa); end
        fill(2);
        fb = build();
        for (int k = 0; k < NF - 1; k++) begin
            drive(cur[k], 1'b0, a);
            vectors++;
            if (a !== 1'b1) begin miscompares++; $display("FAIL bp_accept[%0d]: got %b want 1", k, a); end
        end
        s_valid = 1'b1; s_data = cur[NF-1]; s_last = 1'b1;
        vectors++;
        if (s_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stall: got s_ready %b want 0", s_ready); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (m_valid !== 1'b1 || m_data !== fa || s_ready !== 1'b0) begin
                miscompares++; $display("FAIL bp_hold[%0d]: got %b/%b/%h want 1/0/%h", i, m_valid, s_ready, m_data, fa);
            end
        end
        m_ready = 1'b1;
        #1;
        vectors++;
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got s_ready %b want 1", s_ready); end
        @(negedge clk);
        idle();
        vectors++;
        if (m_valid !== 1'b1 || m_data !== fb) begin miscompares++; $display("FAIL bp_second: got %b/%h want 1/%h", m_valid, m_data, fb); end
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        logic a;
        int pulses;
        pulses = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 3 * NF; i++) begin
            int k;
            k = i % NF;
            if (k == 0) begin
                fill(3 + i / NF);
                exp_q.push_back(build());
            end
            drive(cur[k], k == NF - 1, a);
            vectors++;
            if (a !== 1'b1) begin miscompares++; $display("FAIL b2b_accept[%0d]: got %b want 1", i, a); end
            vectors++;
            if (m_valid !== (k == NF - 1)) begin miscompares++; $display("FAIL b2b_m_valid[%0d]: got %b want %b", i, m_valid, k == NF - 1); end
            if (m_valid === 1'b1) begin
                pulses++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL b2b_extra[%0d]: got frame %h want none", i, m_data);
                end else if (m_data !== exp_q[0]) begin
                    miscompares++; $display("FAIL b2b_m_data[%0d]: got %h want %h", i, m_data, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        idle();
        vectors++;
        if (pulses != 3) begin miscompares++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic a;
        logic [DW-1:0] fc;
        m_ready = 1'b0;
        fill(6);
        for (int k = 0; k < NF; k++) drive(cur[k], k == NF - 1, a);
        vectors++;
        if (m_valid !== 1'b1) begin miscompares++; $display("FAIL rst_held: got %b want 1", m_valid); end
        fill(7);
        for (int k = 0; k < 20; k++) drive(cur[k], 1'b0, a);
        idle();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (m_valid !== 1'b0 || m_data !== '0 || s_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_async: got %b/%b/%h want 0/1/0", m_valid, s_ready, m_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        fill(8);
        fc = build();
        for (int k = 0; k < NF; k++) begin
            drive(cur[k], k == NF - 1, a);
            vectors++;
            if (m_valid !== (k == NF - 1)) begin miscompares++; $display("FAIL rst_after_m_valid[%0d]: got %b want %b", k, m_valid, k == NF - 1); end
        end
        idle();
        vectors++;
        if (m_data !== fc) begin miscompares++; $display("FAIL rst_after_m_data: got %h want %h", m_data, fc); end
        @(negedge clk);
    endtask

    task automatic test_frame_check();
        logic a;
        logic [DW-1:0] fx;
        m_ready = 1'b1;
`ifdef LNQ_FRAME_CHECK_EN
        fill(9);
        for (int k = 0; k < 10; k++) drive(cur[k], k == 9, a);
        idle();
        vectors++;
        if (frame_err !== 1'b1 || m_valid !== 1'b0) begin miscompares++; $display("FAIL early_last: got err %b valid %b want 1/0", frame_err, m_valid); end
        @(negedge clk);
        vectors++;
        if (frame_err !== 1'b0 || m_valid !== 1'b0) begin miscompares++; $display("FAIL early_last_pulse: got err %b valid %b want 0/0", frame_err, m_valid); end
        fill(10);
        fx = build();
        for (int k = 0; k < NF; k++) begin
            drive(cur[k], k == NF - 1, a);
            vectors++;
            if (m_valid !== (k == NF - 1) || frame_err !== 1'b0) begin
                miscompares++; $display("FAIL fc_good[%0d]: got valid %b err %b want %b/0", k, m_valid, frame_err, k == NF - 1);
            end
        end
        vectors++;
        if (m_data !== fx) begin miscompares++; $display("FAIL fc_good_data: got %h want %h", m_data, fx); end
        fill(11);
        for (int k = 0; k < NF; k++) drive(cur[k], 1'b0, a);
        idle();
        vectors++;
        if (frame_err !== 1'b1 || m_valid !== 1'b0) begin miscompares++; $display("FAIL missing_last: got err %b valid %b want 1/0", frame_err, m_valid); end
        vectors++;
        if (m_data !== fx) begin miscompares++; $display("FAIL missing_last_data: got %h want %h", m_data, fx); end
        @(negedge clk);
        vectors++;
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL missing_last_pulse: got %b want 0", frame_err); end
        fill(12);
        fx = build();
        for (int k = 0; k < NF; k++) begin
            drive(cur[k], k == NF - 1, a);
            vectors++;
            if (m_valid !== (k == NF - 1)) begin miscompares++; $display("FAIL fc_recover[%0d]: got %b want %b", k, m_valid, k == NF - 1); end
        end
        idle();
        vectors++;
        if (m_data !== fx) begin miscompares++; $display("FAIL fc_recover_data: got %h want %h", m_data, fx); end
`else
        fill(9);
        fx = build();
        for (int k = 0; k < NF; k++) begin
            drive(cur[k], k == 9, a);
            vectors++;
            if (m_valid !== (k == NF - 1) || frame_err !== 1'b0) begin
                miscompares++; $display("FAIL nofc_count[%0d]: got valid %b err %b want %b/0", k, m_valid, frame_err, k == NF - 1);
            end
        end
        idle();
        vectors++;
        if (m_data !== fx) begin miscompares++; $display("FAIL nofc_data: got %h want %h", m_data, fx); end
`endif
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_full_frame();
        test_thresholds();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_frame_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hgcal_input_quant_pack.md
Name: hgcal_input_quant_pack

Overview:
- Front-end stage directly upstream of the first LUT neuron layer of the HGCAL autoencoder.
- Accepts a stream of unsigned sensor samples over valid/ready and quantises each to Q_W bits against fixed thresholds.
- Packs N_FEAT quantised features into one flat frame vector and presents it, registered, to layer 0.
- Neuron input slices are taken from that vector by the layer-0 wiring.

Parameters:
IN_W, 8, width of each unsigned input sample
Q_W, 2, quantised feature width; fixed at 2 (three thresholds)
N_FEAT, 48, features per frame
THR0, 32, sample >= THR0 -> code at least 1
THR1, 96, sample >= THR1 -> code at least 2
THR2, 192, sample >= THR2 -> code 3; require THR0 < THR1 < THR2

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  stage can accept a sample
s_data  in  IN_W  unsigned sample
s_last  in  1  final sample of frame (used only with LNQ_FRAME_CHECK_EN)
m_valid  out  1  packed frame valid
m_ready  in  1  downstream accepts frame
m_data  out  N_FEAT*Q_W  packed frame; feature k at bits [k*Q_W +: Q_W]
frame_err  out  1  one-cycle pulse on framing error (tied 0 without LNQ_FRAME_CHECK_EN)

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, acc=0.
  - m_valid=0, m_data=0, frame_err=0, s_ready=1 on the first cycle after release.
- Quantise, combinational on s_data:
  - s_data>=THR2 -> 3
  - else s_data>=THR1 -> 2
  - else s_data>=THR0 -> 1
  - else 0
  - Unsigned comparisons only.
- Accept: s_valid && s_ready on a rising edge.
  - acc[cnt*Q_W +: Q_W] <= code.
  - cnt increments.
- cnt is the collect state, range 0..N_FEAT-1; there is no other FSM.
- Frame complete: accept while cnt==N_FEAT-1.
  - m_data <= acc with the final slot replaced by the current code.
  - m_valid <= 1, cnt <= 0.
  - m_valid rises the cycle after the last accepted sample (1-cycle latency).
  - acc need not be cleared: every slot is rewritten before the next transfer.
- s_ready = !(cnt==N_FEAT-1 && m_valid && !m_ready).
  - Collection of the next frame proceeds while the previous frame is held.
  - Stall occurs only on the final sample.
- Output handshake:
  - m_data is stable while m_valid && !m_ready.
  - m_valid && m_ready with no new completion -> m_valid <= 0 next cycle.
  - Completion on the same edge as m_ready drain -> m_valid stays 1 and m_data is replaced; back-to-back frames lose no cycle.
- s_ready does not depend combinationally on s_valid.
- Wrap-around: cnt returns to 0 only via frame completion or a framing error.
- Reset mid-frame or mid-hold discards the partial frame and the held frame; cnt=0, m_valid=0.

Optional Feature:
LNQ_FRAME_CHECK_EN
- Defined:
  - An accepted sample with s_last=1 and cnt!=N_FEAT-1 (early last) pulses frame_err for one cycle.
  - In that case cnt <= 0, the partial frame is dropped, and m_valid/m_data are unaffected.
  - An accepted sample with cnt==N_FEAT-1 and s_last=0 (missing last) pulses frame_err.
  - In that case the frame is dropped (no transfer, m_valid unchanged) and cnt <= 0.
- Undefined:
  - s_last is ignored; framing is purely by count.
  - frame_err is constant 0.

Test Plan:
1. Reset, then 48 samples with s_last on the 48th, m_ready=1 -> one m_valid pulse the cycle after sample 48; m_data feature k = code of sample k.
2. Threshold boundaries: samples 31, 32, 95, 96, 191, 192, 255, 0 -> codes 0, 1, 1, 2, 2, 3, 3, 0 in slots 0..7.
3. m_ready=0 after frame 1 completes; send 47 samples of frame 2 -> all accepted. Sample 48 -> s_ready=0 and m_data unchanged. Raise m_ready -> frame 1 drains; frame 2 completes on the same edge; m_valid stays 1 with the new data.
4. Continuous s_valid with m_ready=1 for 3 frames -> 144 samples in 144 cycles, 3 m_valid pulses spaced 48 cycles apart.
5. rst_n low at sample 20 of a frame -> m_valid=0 immediately. After release, a full 48-sample frame produces correct data with no residue.
6. LNQ_FRAME_CHECK_EN: s_last on sample 10 -> frame_err pulse, no m_valid; the next 48-sample frame is output correctly. s_last=0 on sample 48 -> frame_err pulse, frame dropped.
